// File: rtl/inst_sram_axi_rd_pkg.sv
// Shared AXI constants, channel IDs and AR-slot state encoding for the
// instruction-side and (future) data-side sram-to-AXI read bridges.
package inst_sram_axi_rd_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  localparam logic [3:0] INST_ARID = 4'd0;
  localparam logic [3:0] DATA_ARID = 4'd1;

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;

endpackage

// File: rtl/inst_sram_axi_rd.sv
// Instruction fetch bridge: sram-like request/response port to single-beat
// in-order AXI reads, with up to MAX_OUTSTANDING reads in flight.
module inst_sram_axi_rd
  import inst_sram_axi_rd_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = INST_ARID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic [0:0]  state_reg;
  logic [2:0]  cnt_reg;
  logic [2:0]  cnt_next;
  logic        arvalid_reg;
  logic [31:0] araddr_reg;
  logic [2:0]  arsize_reg;
  logic        rready_reg;
  logic        data_ok_reg;
  logic [31:0] rdata_reg;
  logic        bus_err_reg;

  logic accept;
  logic ar_fire;
  logic r_fire;
  logic r_take;

  // Single-beat, single-ID reads: the returned ID and last flag carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast};

  // Acceptance never looks at arready so the fetch stage sees no AXI combinational path.
  assign accept  = inst_sram_req && (state_reg == AR_IDLE) && (cnt_reg < MAX_CNT);
  assign ar_fire = arvalid_reg && arready;
  assign r_fire  = rvalid && rready_reg;
  assign r_take  = r_fire && (cnt_reg != 3'd0);

  always_comb begin
    cnt_next = cnt_reg;
    case ({accept, r_take})
      2'b10:   cnt_next = cnt_reg + 3'd1;
      2'b01:   cnt_next = cnt_reg - 3'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= AR_IDLE;
      arvalid_reg <= 1'b0;
      araddr_reg  <= 32'd0;
      arsize_reg  <= 3'd0;
    end else begin
      case (state_reg)
        AR_IDLE: begin
          if (accept) begin
            state_reg   <= AR_BUSY;
            arvalid_reg <= 1'b1;
            araddr_reg  <= inst_sram_addr;
            arsize_reg  <= {1'b0, inst_sram_size};
          end
        end
        default: begin
          if (ar_fire) begin
            state_reg   <= AR_IDLE;
            arvalid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= 3'd0;
      rready_reg  <= 1'b0;
      data_ok_reg <= 1'b0;
      rdata_reg   <= 32'd0;
      bus_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      rready_reg  <= 1'b1;
      data_ok_reg <= r_take;
      if (r_take) begin
        rdata_reg <= rdata;
      end
      // Error responses are still delivered; spurious beats are dropped but flagged.
      if (r_fire && ((cnt_reg == 3'd0) || (rresp != AXI_RESP_OKAY))) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  assign inst_sram_addr_ok = accept;
  assign inst_sram_data_ok = data_ok_reg;
  assign inst_sram_rdata   = rdata_reg;
  assign arid              = ARID_VAL;
  assign araddr            = araddr_reg;
  assign arlen             = AXI_LEN_SINGLE;
  assign arsize            = arsize_reg;
  assign arburst           = AXI_BURST_INCR;
  assign arvalid           = arvalid_reg;
  assign rready            = rready_reg;
  assign bus_err           = bus_err_reg;

endmodule
